timer_counter: RTL and testbench

- Memory-mapped down-counting timer on the system bridge's T1/T2 ports. One instance per slot: T1 at 0x7F00–0x7F0B, T2 at 0x7F10–0x7F1B.
- Holds CTRL, PRESET and COUNT registers. Counts PRESET down to zero and raises an interrupt request.
- The request feeds bridge IRQ1/IRQ2, which go into HWInt.
- Two modes:
  - mode 0: one-shot; interrupt holds until software rewrites CTRL.
  - mode 1: auto-reload; one-cycle interrupt pulse per period.

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_counter.sv | 90 +++++++++
 tb/tb_timer_counter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
package timer_pkg;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] PRESET_OFF = 4'h4;
  localparam logic [3:0] COUNT_OFF  = 4'h8;

  localparam logic [1:0] CTRL_IDX   = CTRL_OFF[3:2];
  localparam logic [1:0] PRESET_IDX = PRESET_OFF[3:2];
  localparam logic [1:0] COUNT_IDX  = COUNT_OFF[3:2];

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Modes 1x fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Down-counting timer with CTRL/PRESET/COUNT registers and an interrupt request.
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]   ctrl;
  logic [31:0]  preset;
  logic [31:0]  count;
  timer_state_e state;
  logic         irq_flag;

  logic [1:0]   reg_sel;
  logic         wr_hit;
  logic         wr_ctrl;
  logic         wr_preset;
  logic         unused_bits;

  assign reg_sel     = addr[3:2];
  assign wr_hit      = we && (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl     = wr_hit && (reg_sel == CTRL_IDX);
  assign wr_preset   = wr_hit && (reg_sel == PRESET_IDX);
  assign unused_bits = ^{addr[1:0], wdata[31:4]};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      CTRL_IDX:   rdata = {28'd0, ctrl};
      PRESET_IDX: rdata = preset;
      COUNT_IDX:  rdata = count;
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_flag & ctrl[CTRL_IM];

  // Software CTRL writes are applied after the FSM so they override its EN clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      state    <= ST_IDLE;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl[CTRL_EN]) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= '0;
            state    <= ST_INT;
            irq_flag <= 1'b1;
          end
        end
        ST_INT: begin
          state <= ST_IDLE;
          if (is_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) irq_flag <= 1'b0;
          else ctrl[CTRL_EN] <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_ctrl) begin
        ctrl     <= wdata[3:0];
        irq_flag <= 1'b0;
      end
      if (wr_preset) preset <= wdata;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues expected rdata/irq, monitor checks at negedge.
module tb_timer_counter;

  localparam logic [31:0] CT = 32'h0000_7F00;
  localparam logic [31:0] PR = 32'h0000_7F04;
  localparam logic [31:0] CO = 32'h0000_7F08;
  localparam logic [31:0] RS = 32'h0000_7F0C;

  localparam logic [31:0] OS_CNT [8]  = '{0, 0, 5, 4, 3, 2, 1, 0};
  localparam bit          OS_IRQ [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
  localparam logic [31:0] AR_CNT [13] = '{0, 0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0};
  localparam bit          AR_IRQ [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
  localparam logic [31:0] MK_CNT [6]  = '{3, 3, 2, 1, 0, 0};
  localparam logic [31:0] PZ_CNT [4]  = '{0, 0, 10, 9};
  localparam logic [31:0] RL_CNT [6]  = '{7, 7, 2, 1, 0, 0};
  localparam bit          RL_IRQ [6]  = '{0, 0, 0, 0, 1, 1};
  localparam bit          Z_IRQ  [5]  = '{0, 0, 0, 1, 1};

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  timer_counter #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (rdata !== mon_e.rd || irq !== mon_e.irq) begin
        n_fail++;
        $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                 mon_e.name, rdata, irq, mon_e.rd, mon_e.irq);
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] r, input logic i);
    exp_t e;
    e.name = nm;
    e.rd   = r;
    e.irq  = i;
    sb.push_back(e);
  endtask

  // Drive inputs for the next edge; checks queued afterwards see the state after the edge just passed.
  task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge clk);
    #1;
    addr  = a;
    we    = w;
    wdata = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] r, input logic i, input string nm);
    cyc(a, 1'b0, '0);
    push(nm, r, i);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] r, input logic i, input string nm);
    cyc(a, 1'b1, d);
    push(nm, r, i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    addr  = CT;
    we    = 1'b0;
    wdata = '0;

    rd(CT, 0, 0, "rst_ctrl");
    rd(PR, 0, 0, "rst_preset");
    rd(CO, 0, 0, "rst_count");
    #2 rst_n = 1'b1;
    rd(CO, 0, 0, "rst_release");

    // One-shot, PRESET=5
    wr(PR, 5, 0, 0, "os_pre");
    wr(CT, 32'h9, 0, 0, "os_ctrl");
    for (int unsigned i = 0; i < 8; i++) rd(CO, OS_CNT[i], OS_IRQ[i], $sformatf("os_count%0d", i));
    rd(CT, 32'h8, 1, "os_en_cleared");
    rd(CO, 0, 1, "os_irq_held");
    wr(CT, 0, 32'h8, 1, "os_clr_pre");
    rd(CT, 0, 0, "os_clr");

    // Auto-reload, PRESET=3
    wr(PR, 3, 5, 0, "ar_pre");
    wr(CT, 32'hB, 0, 0, "ar_ctrl");
    for (int unsigned i = 0; i < 13; i++) rd(CO, AR_CNT[i], AR_IRQ[i], $sformatf("ar_count%0d", i));
    wr(CT, 0, 32'hB, 0, "ar_stop");
    wr(PR, 2, 3, 0, "ar_pre2");
    rd(CO, 3, 0, "ar_load_old_preset");
    rd(CO, 3, 0, "ar_en_off_hold");

    // Masked interrupt, PRESET=2
    wr(CT, 32'h1, 0, 0, "mk_ctrl");
    for (int unsigned i = 0; i < 6; i++) rd(CO, MK_CNT[i], 0, $sformatf("mk_count%0d", i));
    wr(CT, 32'h8, 0, 0, "mk_en_cleared");
    rd(CT, 32'h8, 0, "mk_im_flag_cleared");

    // Pause at 7, then reload from a new PRESET
    wr(PR, 10, 2, 0, "pz_pre");
    wr(CT, 32'h9, 32'h8, 0, "pz_ctrl");
    for (int unsigned i = 0; i < 4; i++) rd(CO, PZ_CNT[i], 0, $sformatf("pz_count%0d", i));
    wr(CT, 32'h8, 32'h9, 0, "pz_stop");
    for (int unsigned i = 0; i < 3; i++) rd(CO, 7, 0, $sformatf("pz_hold%0d", i));
    wr(PR, 2, 10, 0, "rl_pre");
    wr(CT, 32'h9, 32'h8, 0, "rl_ctrl");
    for (int unsigned i = 0; i < 6; i++) rd(CO, RL_CNT[i], RL_IRQ[i], $sformatf("rl_count%0d", i));
    wr(CO, 32'h55, 0, 1, "cw_write");
    rd(CO, 0, 1, "cw_ignored");
    wr(CT, 0, 32'h8, 1, "rl_clr_pre");
    rd(CT, 0, 0, "rl_clr");

    // PRESET=0 goes straight to INT, no wrap
    wr(PR, 0, 2, 0, "z_pre");
    wr(CT, 32'h9, 0, 0, "z_ctrl");
    for (int unsigned i = 0; i < 5; i++) rd(CO, 0, Z_IRQ[i], $sformatf("z_count%0d", i));
    rd(CT, 32'h8, 1, "z_ctrl_after");

    // Asynchronous reset with irq pending
    cyc(CT, 1'b0, '0);
    #1 rst_n = 1'b0;
    push("arst_immediate", 0, 0);
    rd(PR, 0, 0, "arst_preset");
    #2 rst_n = 1'b1;

    // Address qualification and reserved slot
    cyc(32'h0000_7F14, 1'b1, 32'h77);
    cyc(32'h0000_7F10, 1'b1, 32'hF);
    rd(PR, 0, 0, "aq_preset");
    rd(CT, 0, 0, "aq_ctrl");
    wr(RS, 32'hFFFF, 0, 0, "rsv_read");
    rd(CT, 0, 0, "rsv_ctrl");
    rd(PR, 0, 0, "rsv_preset");

    cyc(CT, 1'b0, '0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
